// File: rtl/irq_route_cfg_ctrl.sv
// Interrupt routing table controller: boot-time default sweep, then host read/write of route entries.
// Responses one cycle after acceptance; req_ready drops during the sweep, response cycle and reinit.
module irq_route_cfg_ctrl #(
   parameter int         NUM_SLOTS         = 5,
   parameter int         NUM_TILE_INT_CH   = 2,
   parameter int         NUM_CPU_INT       = 4,
   parameter int         NUM_CPU_NMI       = 2,
   parameter int         CFG_ADDR_WIDTH    = 8,
   parameter logic [7:0] DEFAULT_INT_ROUTE = 8'h80,
   parameter logic [7:0] DEFAULT_NMI_ROUTE = 8'h80
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      reinit,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wr,
   input  logic [CFG_ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]                req_data,
   output logic                      rsp_valid,
   output logic                      rsp_err,
   output logic [7:0]                rsp_rdata,
   output logic                      init_done,
   output logic                      cfg_wr_en,
   output logic                      cfg_rd_en,
   output logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
   output logic [31:0]               cfg_wdata
);
   localparam int N_INT = NUM_SLOTS * NUM_TILE_INT_CH;
   localparam int N     = N_INT + NUM_SLOTS;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CFG_ADDR_WIDTH-1:0] N_A     = CFG_ADDR_WIDTH'(N);
   localparam logic [CFG_ADDR_WIDTH-1:0] N_INT_A = CFG_ADDR_WIDTH'(N_INT);
   localparam logic [CFG_ADDR_WIDTH-1:0] LAST_A  = CFG_ADDR_WIDTH'(N - 1);
   localparam logic [4:0] INT_LIM = 5'(NUM_CPU_INT);
   localparam logic [4:0] NMI_LIM = 5'(NUM_CPU_NMI);

   typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

   state_t                    state_q, state_d;
   logic [CFG_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [7:0]                shadow [N];
   logic                      shw_en;
   logic [IDX_W-1:0]          shw_idx;
   logic [7:0]                shw_dat;
   logic                      init_done_d, rsp_valid_d, rsp_err_d, cfg_wr_en_d;
   logic [7:0]                rsp_rdata_d;
   logic [CFG_ADDR_WIDTH-1:0] cfg_addr_d;
   logic [31:0]               cfg_wdata_d;
   logic                      accept, addr_ok, is_nmi, idx_ok, wr_legal;

   // init_done gates readiness so the last sweep write is never overlapped by a request
   assign req_ready = (state_q == IDLE) && init_done && !reinit;
   assign accept    = req_ready && req_valid;
   assign addr_ok   = req_addr < N_A;
   assign is_nmi    = req_addr >= N_INT_A;
   assign idx_ok    = !req_data[7] || ({1'b0, req_data[3:0]} < (is_nmi ? NMI_LIM : INT_LIM));
   assign wr_legal  = addr_ok && (req_data[6:4] == 3'b000) && idx_ok;
   assign cfg_rd_en = 1'b0;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      init_done_d = init_done;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      cfg_wr_en_d = 1'b0;
      cfg_addr_d  = '0;
      cfg_wdata_d = '0;
      shw_en      = 1'b0;
      shw_idx     = ptr_q[IDX_W-1:0];
      shw_dat     = '0;
      case (state_q)
         INIT: begin
            init_done_d = 1'b0;
            cfg_wr_en_d = 1'b1;
            cfg_addr_d  = ptr_q;
            shw_en      = 1'b1;
            shw_dat     = (ptr_q < N_INT_A) ? DEFAULT_INT_ROUTE : DEFAULT_NMI_ROUTE;
            cfg_wdata_d = {24'h0, shw_dat};
            if (ptr_q == LAST_A) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + CFG_ADDR_WIDTH'(1);
            end
         end
         IDLE: begin
            if (reinit) begin
               state_d     = INIT;
               ptr_d       = '0;
               init_done_d = 1'b0;
            end else begin
               init_done_d = 1'b1;
               if (accept) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  shw_idx     = req_addr[IDX_W-1:0];
                  if (req_wr && wr_legal) begin
                     cfg_wr_en_d = 1'b1;
                     cfg_addr_d  = req_addr;
                     cfg_wdata_d = {24'h0, req_data};
                     shw_en      = 1'b1;
                     shw_dat     = req_data;
                     rsp_rdata_d = req_data;
                  end else if (!req_wr && addr_ok) begin
                     rsp_rdata_d = shadow[req_addr[IDX_W-1:0]];
                  end else begin
                     rsp_err_d = 1'b1;
                  end
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         ptr_q     <= '0;
         init_done <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         cfg_wr_en <= 1'b0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         for (int i = 0; i < N; i++) shadow[i] <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         init_done <= init_done_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rsp_rdata <= rsp_rdata_d;
         cfg_wr_en <= cfg_wr_en_d;
         cfg_addr  <= cfg_addr_d;
         cfg_wdata <= cfg_wdata_d;
         if (shw_en) shadow[shw_idx] <= shw_dat;
      end
   end
endmodule

// File: tb/tb_irq_route_cfg_ctrl.sv
// Bench for irq_route_cfg_ctrl: directed sweep/reinit/reset steps plus random requests against a table model.
module tb_irq_route_cfg_ctrl;
   localparam int N_INT = 10;
   localparam int N     = 15;
   localparam int NCPU_INT = 4;
   localparam int NCPU_NMI = 2;

   logic        clk, rst, reinit, req_valid, req_ready, req_wr;
   logic [7:0]  req_addr, req_data, rsp_rdata, cfg_addr;
   logic        rsp_valid, rsp_err, init_done, cfg_wr_en, cfg_rd_en;
   logic [31:0] cfg_wdata;

   int         tests = 0;
   int         fails = 0;
   bit         mon_en = 0;
   logic [7:0] model [N];

   irq_route_cfg_ctrl dut (
      .clk(clk), .rst(rst), .reinit(reinit),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .init_done(init_done), .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The config bus must idle at zero and never issue reads
   always @(negedge clk) begin
      if (mon_en) begin
         check("cfg_rd_en_zero", 32'(cfg_rd_en), 32'd0);
         if (!cfg_wr_en) begin
            check("cfg_addr_idle", 32'(cfg_addr), 32'd0);
            check("cfg_wdata_idle", cfg_wdata, 32'd0);
         end
      end
   end

   function automatic bit legal(input int addr, input logic [7:0] d);
      int lim;
      if (addr >= N) return 1'b0;
      if (d[6:4] != 3'b000) return 1'b0;
      lim = (addr < N_INT) ? NCPU_INT : NCPU_NMI;
      if (d[7] && int'(d[3:0]) >= lim) return 1'b0;
      return 1'b1;
   endfunction

   // Expects the sweep to begin at the next edge; ends in the first init_done cycle
   task automatic check_sweep(input string tag);
      for (int i = 0; i < N; i++) begin
         tick();
         check({tag, "_wr_en"}, 32'(cfg_wr_en), 32'd1);
         check({tag, "_addr"}, 32'(cfg_addr), 32'(i));
         check({tag, "_data"}, cfg_wdata, (i < N_INT) ? 32'h80 : 32'h80);
         check({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
         if (i < N - 1) check({tag, "_busy"}, 32'(init_done), 32'd0);
      end
      for (int i = 0; i < N; i++) model[i] = 8'h80;
      tick();
      check({tag, "_end_wr"}, 32'(cfg_wr_en), 32'd0);
      check({tag, "_init_done"}, 32'(init_done), 32'd1);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic do_req(input logic wr, input int addr, input logic [7:0] data);
      logic       e_err, e_wen;
      logic [7:0] e_rd;
      int         n;
      e_wen = 1'b0;
      e_err = 1'b1;
      e_rd  = 8'h00;
      if (wr) begin
         if (legal(addr, data)) begin
            e_wen = 1'b1; e_err = 1'b0; e_rd = data;
         end
      end else if (addr < N) begin
         e_err = 1'b0; e_rd = model[addr];
      end
      req_valid = 1'b1; req_wr = wr; req_addr = 8'(addr); req_data = data;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'(e_err));
      check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
      check("rsp_wr_en", 32'(cfg_wr_en), 32'(e_wen));
      if (e_wen) begin
         check("rsp_cfg_addr", 32'(cfg_addr), 32'(addr));
         check("rsp_cfg_wdata", cfg_wdata, 32'(data));
         model[addr] = data;
      end
      tick();
      check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      check("back_idle_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       wr;
      int         addr;
      logic [7:0] data;
      rst = 1'b1; reinit = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
      req_addr = 8'h00; req_data = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         mon_en = 1'b1;
         check("rst_wr_en", 32'(cfg_wr_en), 32'd0);
         check("rst_init_done", 32'(init_done), 32'd0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_req_ready", 32'(req_ready), 32'd0);
      end
      rst = 1'b0;
      check_sweep("boot");

      do_req(1'b1, 3, 8'h82);
      do_req(1'b0, 3, 8'h00);
      do_req(1'b1, 3, 8'h84);
      do_req(1'b1, 12, 8'h82);
      do_req(1'b1, 0, 8'h90);
      do_req(1'b1, 15, 8'h00);
      do_req(1'b0, 3, 8'h00);
      do_req(1'b0, 12, 8'h00);
      do_req(1'b0, 0, 8'h00);
      do_req(1'b1, 11, 8'h07);
      do_req(1'b0, 11, 8'h00);
      do_req(1'b1, 13, 8'h81);
      do_req(1'b0, 20, 8'h00);

      for (int k = 0; k < 80; k++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = int'($urandom_range(0, 17));
         if ($urandom_range(0, 1) == 0)
            data = {1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 5))};
         else
            data = 8'($urandom);
         do_req(wr, addr, data);
      end
      for (int a = 0; a < N; a++) do_req(1'b0, a, 8'h00);

      // reinit beats a same-cycle request, which waits out the sweep
      reinit = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'd5; req_data = 8'h81;
      #1;
      check("reinit_blocks_ready", 32'(req_ready), 32'd0);
      tick();
      reinit = 1'b0;
      check("reinit_no_rsp", 32'(rsp_valid), 32'd0);
      check("reinit_done_low", 32'(init_done), 32'd0);
      check("reinit_gap_wr", 32'(cfg_wr_en), 32'd0);
      check_sweep("reinit");
      tick();
      req_valid = 1'b0;
      check("held_req_rsp", 32'(rsp_valid), 32'd1);
      check("held_req_err", 32'(rsp_err), 32'd0);
      check("held_req_wr_en", 32'(cfg_wr_en), 32'd1);
      check("held_req_addr", 32'(cfg_addr), 32'd5);
      model[5] = 8'h81;
      tick();
      do_req(1'b0, 3, 8'h00);
      do_req(1'b0, 5, 8'h00);

      // reset in the middle of a sweep
      rst = 1'b1;
      tick();
      check("rst2_done_low", 32'(init_done), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("part_sweep_addr", 32'(cfg_addr), 32'(i));
         check("part_sweep_wr", 32'(cfg_wr_en), 32'd1);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("midsweep_rst_wr", 32'(cfg_wr_en), 32'd0);
      end
      rst = 1'b0;
      check_sweep("resweep");

      // reset coinciding with a request gives no response
      do_req(1'b1, 2, 8'h83);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'd2;
      rst = 1'b1;
      tick();
      check("rst_req_no_rsp", 32'(rsp_valid), 32'd0);
      req_valid = 1'b0;
      tick();
      rst = 1'b0;
      check_sweep("final");
      for (int a = 0; a < N; a++) do_req(1'b0, a, 8'h00);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
